// File: rtl/jtdd_colmix_if.sv
// Layer pixels, blanking, CPU palette port and RGB output of the colour mixer.
// Master drives layers/blanking/CPU bus; slave is the mixer.
interface jtdd_colmix_if;
  logic       pxl_cen;
  logic       cen_Q;
  logic [9:0] cpu_AB;
  logic       pal_cs;
  logic       cpu_wrn;
  logic [7:0] cpu_dout;
  logic [7:0] pal_dout;
  logic [7:0] char_pxl;
  logic [7:0] scr_pxl;
  logic [7:0] obj_pxl;
  logic       LHBL;
  logic       LVBL;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       LHBL_dly;
  logic       LVBL_dly;

  modport master (
    output pxl_cen, cen_Q, cpu_AB, pal_cs, cpu_wrn, cpu_dout,
           char_pxl, scr_pxl, obj_pxl, LHBL, LVBL,
    input  pal_dout, red, green, blue, LHBL_dly, LVBL_dly
  );

  modport slave (
    input  pxl_cen, cen_Q, cpu_AB, pal_cs, cpu_wrn, cpu_dout,
           char_pxl, scr_pxl, obj_pxl, LHBL, LVBL,
    output pal_dout, red, green, blue, LHBL_dly, LVBL_dly
  );
endinterface

// File: rtl/jtdd_colmix.sv
// Colour mixer: layer priority, 512-entry palette lookup, blanking; 3 pxl_cen latency.
// No backpressure: video registers simply hold while pxl_cen is low; CPU port runs every clk.
module jtdd_colmix #(
  parameter SIMFILE_RG = "pal_rg.bin",
  parameter SIMFILE_B  = "pal_b.bin"
) (
  input  logic         clk,
  input  logic         rst,
  jtdd_colmix_if.slave bus
);

  typedef struct packed {
    logic [8:0] addr;
    logic       lhbl;
    logic       lvbl;
  } st1_t;

  typedef struct packed {
    logic [7:0] rg;
    logic [3:0] b;
    logic       lhbl;
    logic       lvbl;
  } st2_t;

  logic [7:0] rg_ram [0:511];
  logic [7:0] b_ram  [0:511];

  logic       char_opaque;
  logic       obj_opaque;
  logic       scr_front;
  logic [8:0] pal_addr;
  logic       rg_we;
  logic       b_we;
  st1_t       st1;
  st2_t       st2;

  // Preload images are only consumed by simulation wrappers around this block.
  if ($bits(SIMFILE_RG) == 0 || $bits(SIMFILE_B) == 0) begin : g_no_preload
  end

  // Priority: char > prioritised opaque scroll > obj > scroll background.
  always_comb begin
    char_opaque = bus.char_pxl[3:0] != 4'd0;
    obj_opaque  = bus.obj_pxl[3:0]  != 4'd0;
    scr_front   = bus.scr_pxl[7] && (bus.scr_pxl[3:0] != 4'd0);
    pal_addr    = {2'b10, bus.scr_pxl[6:0]};
    if (char_opaque) begin
      pal_addr = {2'b00, bus.char_pxl[6:0]};
    end else if (scr_front) begin
      pal_addr = {2'b10, bus.scr_pxl[6:0]};
    end else if (obj_opaque) begin
      pal_addr = {2'b01, bus.obj_pxl[6:0]};
    end
  end

  assign rg_we = bus.pal_cs && !bus.cpu_wrn && !bus.cpu_AB[9] && bus.cen_Q;
  assign b_we  = bus.pal_cs && !bus.cpu_wrn &&  bus.cpu_AB[9] && bus.cen_Q;

  // Palette banks are never reset; their contents survive rst.
  always_ff @(posedge clk) begin
    if (rg_we) begin
      rg_ram[bus.cpu_AB[8:0]] <= bus.cpu_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (b_we) begin
      b_ram[bus.cpu_AB[8:0]] <= bus.cpu_dout;
    end
  end

  always_ff @(posedge clk) begin
    bus.pal_dout <= bus.cpu_AB[9] ? b_ram[bus.cpu_AB[8:0]] : rg_ram[bus.cpu_AB[8:0]];
  end

  // Video read samples the RAM before a same-clk CPU write lands, so it sees old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st1          <= '0;
      st2          <= '0;
      bus.red      <= 4'd0;
      bus.green    <= 4'd0;
      bus.blue     <= 4'd0;
      bus.LHBL_dly <= 1'b0;
      bus.LVBL_dly <= 1'b0;
    end else if (bus.pxl_cen) begin
      st1.addr     <= pal_addr;
      st1.lhbl     <= bus.LHBL;
      st1.lvbl     <= bus.LVBL;
      st2.rg       <= rg_ram[st1.addr];
      st2.b        <= b_ram[st1.addr][3:0];
      st2.lhbl     <= st1.lhbl;
      st2.lvbl     <= st1.lvbl;
      bus.LHBL_dly <= st2.lhbl;
      bus.LVBL_dly <= st2.lvbl;
      if (st2.lhbl && st2.lvbl) begin
        bus.red   <= st2.rg[3:0];
        bus.green <= st2.rg[7:4];
        bus.blue  <= st2.b;
      end else begin
        bus.red   <= 4'd0;
        bus.green <= 4'd0;
        bus.blue  <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_jtdd_colmix.sv
// Bench for jtdd_colmix: queue-based pixel model compared every cycle, plus literal checks.
module tb_jtdd_colmix;
  logic clk = 1'b0;
  logic rst = 1'b1;

  jtdd_colmix_if bus ();

  jtdd_colmix dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [8:0] addr;
    bit         lhbl;
    bit         lvbl;
    logic [7:0] rg;
    logic [7:0] b;
  } pix_t;

  logic [7:0] m_rg [0:511];
  logic [7:0] m_b  [0:511];
  pix_t       q[$];
  logic [3:0] e_r, e_g, e_b;
  bit         e_h, e_v;
  bit         e_dout_vld;
  logic [7:0] e_dout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which palette entry a pixel shows, written as plain rules over the three layers.
  function automatic logic [8:0] winner(input logic [7:0] c, input logic [7:0] s, input logic [7:0] o);
    if (c[3:0] != 4'd0)           return 9'h000 + 9'(c[6:0]);
    if (s[7] && s[3:0] != 4'd0)   return 9'h100 + 9'(s[6:0]);
    if (o[3:0] != 4'd0)           return 9'h080 + 9'(o[6:0]);
    return 9'h100 + 9'(s[6:0]);
  endfunction

  function automatic logic [7:0] rnd_pxl();
    logic [7:0] p;
    p = 8'($urandom);
    if ($urandom_range(0, 2) == 0) p[3:0] = 4'h0;
    return p;
  endfunction

  // Model: each pixel fetches its colour one pxl_cen after sampling and leaves after three.
  initial begin : model
    pix_t p;
    pix_t z;
    int   last;
    bit   we;
    z = '{addr: 9'd0, lhbl: 1'b0, lvbl: 1'b0, rg: 8'd0, b: 8'd0};
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        q.push_back(z);
        q.push_back(z);
        e_r = 4'd0; e_g = 4'd0; e_b = 4'd0; e_h = 1'b0; e_v = 1'b0;
        e_dout_vld = 1'b0;
      end else begin
        we = bus.pal_cs && !bus.cpu_wrn && bus.cen_Q;
        if (bus.pxl_cen) begin
          last = q.size() - 1;
          q[last].rg = m_rg[q[last].addr];
          q[last].b  = m_b[q[last].addr];
          p.addr = winner(bus.char_pxl, bus.scr_pxl, bus.obj_pxl);
          p.lhbl = bus.LHBL;
          p.lvbl = bus.LVBL;
          p.rg   = 8'd0;
          p.b    = 8'd0;
          q.push_back(p);
          if (q.size() >= 3) begin
            p   = q.pop_front();
            e_h = p.lhbl;
            e_v = p.lvbl;
            e_r = (p.lhbl && p.lvbl) ? p.rg[3:0] : 4'h0;
            e_g = (p.lhbl && p.lvbl) ? p.rg[7:4] : 4'h0;
            e_b = (p.lhbl && p.lvbl) ? p.b[3:0]  : 4'h0;
          end
        end
        e_dout_vld = bus.pal_cs && !we;
        e_dout     = bus.cpu_AB[9] ? m_b[bus.cpu_AB[8:0]] : m_rg[bus.cpu_AB[8:0]];
        if (we) begin
          if (bus.cpu_AB[9]) m_b[bus.cpu_AB[8:0]]  = bus.cpu_dout;
          else               m_rg[bus.cpu_AB[8:0]] = bus.cpu_dout;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("red",      32'(bus.red),      32'(e_r));
        check("green",    32'(bus.green),    32'(e_g));
        check("blue",     32'(bus.blue),     32'(e_b));
        check("LHBL_dly", 32'(bus.LHBL_dly), 32'(e_h));
        check("LVBL_dly", 32'(bus.LVBL_dly), 32'(e_v));
        if (e_dout_vld) check("pal_dout", 32'(bus.pal_dout), 32'(e_dout));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [9:0] a, input logic [7:0] d);
    bus.cpu_AB = a; bus.cpu_dout = d; bus.pal_cs = 1'b1; bus.cpu_wrn = 1'b0; bus.cen_Q = 1'b1;
    tick();
    bus.pal_cs = 1'b0; bus.cpu_wrn = 1'b1; bus.cen_Q = 1'b0;
  endtask

  task automatic cpu_read(input logic [9:0] a, input logic [7:0] exp, input string name);
    bus.cpu_AB = a; bus.pal_cs = 1'b1; bus.cpu_wrn = 1'b1;
    tick();
    check(name, 32'(bus.pal_dout), 32'(exp));
    bus.pal_cs = 1'b0;
  endtask

  task automatic pixel(input logic [7:0] c, input logic [7:0] s, input logic [7:0] o,
                       input bit h, input bit v);
    bus.char_pxl = c; bus.scr_pxl = s; bus.obj_pxl = o;
    bus.LHBL = h; bus.LVBL = v; bus.pxl_cen = 1'b1;
    tick();
  endtask

  logic [7:0] pc [4] = '{8'h13, 8'h10, 8'h10, 8'h00};
  logic [7:0] ps [4] = '{8'h84, 8'h84, 8'h04, 8'h30};
  logic [7:0] po [4] = '{8'h22, 8'h22, 8'h22, 8'h00};
  logic [3:0] er [4] = '{4'h1, 4'h4, 4'h7, 4'hA};
  logic [3:0] eg [4] = '{4'h2, 4'h5, 4'h8, 4'hB};
  logic [3:0] eb [4] = '{4'h3, 4'h6, 4'h9, 4'hC};

  initial begin : stim
    int r;
    bus.pxl_cen = 1'b0; bus.cen_Q = 1'b0; bus.cpu_AB = 10'd0; bus.pal_cs = 1'b0;
    bus.cpu_wrn = 1'b1; bus.cpu_dout = 8'd0; bus.char_pxl = 8'd0; bus.scr_pxl = 8'd0;
    bus.obj_pxl = 8'd0; bus.LHBL = 1'b0; bus.LVBL = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    check("rst_red",  32'(bus.red),      32'h0);
    check("rst_hbl",  32'(bus.LHBL_dly), 32'h0);
    check("rst_vbl",  32'(bus.LVBL_dly), 32'h0);

    for (int a = 0; a < 1024; a++) cpu_write(10'(a), 8'($urandom));

    // Palette write and readback, then a char pixel through the whole pipeline.
    cpu_write(10'h005, 8'hA5);
    cpu_write(10'h205, 8'h0C);
    cpu_read(10'h005, 8'hA5, "rd_rg");
    cpu_read(10'h205, 8'h0C, "rd_b");
    pixel(8'h05, 8'h00, 8'h00, 1'b1, 1'b1);
    pixel(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    pixel(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    check("char_red",   32'(bus.red),   32'h5);
    check("char_green", 32'(bus.green), 32'hA);
    check("char_blue",  32'(bus.blue),  32'hC);

    // Priority cases; B upper nibble of entry 0x013 must not reach blue.
    cpu_write(10'h013, 8'h21); cpu_write(10'h213, 8'hF3);
    cpu_write(10'h104, 8'h54); cpu_write(10'h304, 8'h06);
    cpu_write(10'h0A2, 8'h87); cpu_write(10'h2A2, 8'h09);
    cpu_write(10'h130, 8'hBA); cpu_write(10'h330, 8'h0C);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) pixel(pc[i], ps[i], po[i], 1'b1, 1'b1);
      else       pixel(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
      if (i >= 2) begin
        check("prio_red",   32'(bus.red),   32'(er[i-2]));
        check("prio_green", 32'(bus.green), 32'(eg[i-2]));
        check("prio_blue",  32'(bus.blue),  32'(eb[i-2]));
      end
    end

    // One blanked pixel among full-white ones.
    cpu_write(10'h130, 8'hFF); cpu_write(10'h330, 8'h0F);
    for (int i = 0; i < 8; i++) begin
      pixel(8'h00, 8'h30, 8'h00, i != 3, 1'b1);
      if (i >= 2) begin
        check("blank_red",  32'(bus.red),      (i == 5) ? 32'h0 : 32'hF);
        check("blank_blue", 32'(bus.blue),     (i == 5) ? 32'h0 : 32'hF);
        check("blank_hbl",  32'(bus.LHBL_dly), (i == 5) ? 32'h0 : 32'h1);
      end
    end

    // Collision: the CPU write lands on the clk the first pixel reads entry 0x013.
    pixel(8'h13, 8'h00, 8'h00, 1'b1, 1'b1);
    bus.cpu_AB = 10'h013; bus.cpu_dout = 8'h65; bus.pal_cs = 1'b1; bus.cpu_wrn = 1'b0; bus.cen_Q = 1'b1;
    pixel(8'h13, 8'h00, 8'h00, 1'b1, 1'b1);
    bus.pal_cs = 1'b0; bus.cpu_wrn = 1'b1; bus.cen_Q = 1'b0;
    pixel(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    check("coll_old_red",   32'(bus.red),   32'h1);
    check("coll_old_green", 32'(bus.green), 32'h2);
    pixel(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    check("coll_new_red",   32'(bus.red),   32'h5);
    check("coll_new_green", 32'(bus.green), 32'h6);

    // Stall for 10 clk with churning inputs; nothing may be lost or duplicated.
    pixel(8'h10, 8'h84, 8'h22, 1'b1, 1'b1);
    pixel(8'h10, 8'h04, 8'h22, 1'b1, 1'b1);
    bus.pxl_cen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.char_pxl = rnd_pxl(); bus.scr_pxl = rnd_pxl(); bus.obj_pxl = rnd_pxl();
      bus.LHBL = 1'($urandom_range(0, 1));
      tick();
    end
    pixel(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    check("stall_red1",  32'(bus.red),  32'h4);
    check("stall_blue1", 32'(bus.blue), 32'h6);
    pixel(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    check("stall_red2",  32'(bus.red),  32'h7);

    // Random traffic on both ports.
    for (int i = 0; i < 3000; i++) begin
      bus.pxl_cen  = ($urandom_range(0, 3) != 0);
      bus.char_pxl = rnd_pxl(); bus.scr_pxl = rnd_pxl(); bus.obj_pxl = rnd_pxl();
      bus.LHBL     = ($urandom_range(0, 7) != 0);
      bus.LVBL     = ($urandom_range(0, 15) != 0);
      r = int'($urandom_range(0, 3));
      bus.cpu_AB   = 10'($urandom);
      bus.cpu_dout = 8'($urandom);
      bus.cen_Q    = 1'($urandom_range(0, 1));
      bus.pal_cs   = (r < 2);
      bus.cpu_wrn  = (r != 0);
      tick();
    end
    bus.pal_cs = 1'b0; bus.cpu_wrn = 1'b1; bus.cen_Q = 1'b0;

    // Mid-frame asynchronous reset, then recovery of the blank delay line.
    cpu_write(10'h130, 8'hFF); cpu_write(10'h330, 8'h0F);
    repeat (4) pixel(8'h00, 8'h30, 8'h00, 1'b1, 1'b1);
    check("pre_rst_red", 32'(bus.red), 32'hF);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_red",   32'(bus.red),      32'h0);
    check("arst_green", 32'(bus.green),    32'h0);
    check("arst_blue",  32'(bus.blue),     32'h0);
    check("arst_hbl",   32'(bus.LHBL_dly), 32'h0);
    check("arst_vbl",   32'(bus.LVBL_dly), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pixel(8'h00, 8'h30, 8'h00, 1'b1, 1'b1);
      check("rel_hbl", 32'(bus.LHBL_dly), (i == 2) ? 32'h1 : 32'h0);
    end
    check("rel_red", 32'(bus.red), 32'hF);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
